riscv_if_prefetch_queue: RTL and testbench

Parametrised fetch front end that replaces the single-entry IF/ID pipe register with a DEPTH-entry prefetch queue. It owns the fetch PC, drives the instruction-memory address, and buffers {PC, instruction} pairs. It presents the oldest pair to the ID stage through a valid/ready handshake. The block sits between instruction memory and the ID stage, and supports branch redirect with a full queue flush.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/riscv_fetch_fifo.sv | 73 +++++++
 rtl/riscv_if_prefetch_queue.sv | 79 +++++++
 tb/tb_riscv_if_prefetch_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned PC_STEP      = 4;

  localparam logic [INSTR_W-1:0] RISCV_NOP = 32'h0000_0013;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO holding fetched {PC, instruction} pairs, with a flush that empties it.
module riscv_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [PW-1:0]    wptr_next, rptr_next;
  logic [CW-1:0]    count_next;

  // Pointer and occupancy next-state; flush wins over push and pop.
  always_comb begin
    wptr_next  = wptr;
    rptr_next  = rptr;
    count_next = count;
    if (flush) begin
      wptr_next  = '0;
      rptr_next  = '0;
      count_next = '0;
    end else begin
      if (push) wptr_next = wptr + PW'(1);
      if (pop)  rptr_next = rptr + PW'(1);
      if (push && !pop)      count_next = count + CW'(1);
      else if (pop && !push) count_next = count - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr_next;
      rptr  <= rptr_next;
      count <= count_next;
    end
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

  // Protocol checks: the controller must never overflow or underflow the queue.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (!(push && full && !pop));
      assert (!(pop && empty));
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/riscv_if_prefetch_queue.sv
// Fetch front end: owns the fetch PC and buffers fetched pairs for the ID stage.
module riscv_if_prefetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned    XLEN     = XLEN_DEFAULT,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       PCSrc,
  input  logic [XLEN-1:0]            PC_Branch,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]         imem_data,
  input  logic                       ID_ready,
  output logic [XLEN-1:0]            PC_ID,
  output logic [INSTR_W-1:0]         INSTRUCTION_ID,
  output logic                       valid_ID,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned     PAIR_W     = XLEN + INSTR_W;
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(PC_STEP - 1);

  logic [XLEN-1:0]   pc_f, pc_next;
  logic              push, pop;
  logic [PAIR_W-1:0] head;

  // Handshake: redirect suppresses both; a pop frees room for a push when full.
  always_comb begin
    pop  = valid_ID && ID_ready && !PCSrc;
    push = !PCSrc && (!full || pop);
  end

  // Fetch PC next-state: redirect to the word-aligned target, else step on push.
  always_comb begin
    pc_next = pc_f;
    if (PCSrc)     pc_next = PC_Branch & ~ALIGN_MASK;
    else if (push) pc_next = pc_f + XLEN'(PC_STEP);
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_f <= RESET_PC;
    else       pc_f <= pc_next;
  end

  riscv_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAIR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (PCSrc),
    .push  (push),
    .pop   (pop),
    .wdata ({pc_f, imem_data}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Head presentation: substitute PC 0 and a NOP whenever the queue is empty.
  always_comb begin
    valid_ID       = !empty;
    PC_ID          = '0;
    INSTRUCTION_ID = RISCV_NOP;
    if (!empty) begin
      PC_ID          = head[PAIR_W-1:INSTR_W];
      INSTRUCTION_ID = head[INSTR_W-1:0];
    end
  end

  assign imem_addr = pc_f;

endmodule

// File: tb/tb_riscv_if_prefetch_queue.sv
// Self-checking bench for riscv_if_prefetch_queue against a queue-based model.
module tb_riscv_if_prefetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH+1);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] SALT  = 32'hA5A5_0000;
  localparam int unsigned VW    = 1 + 32 + 32 + CW + 1 + 1 + 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          PCSrc;
  logic [31:0]   PC_Branch;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_data;
  logic          ID_ready;
  logic [31:0]   PC_ID;
  logic [31:0]   INSTRUCTION_ID;
  logic          valid_ID;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [31:0] mq[$];
  logic [31:0] mpc;

  riscv_if_prefetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PC_Branch(PC_Branch),
    .imem_addr(imem_addr), .imem_data(imem_data), .ID_ready(ID_ready),
    .PC_ID(PC_ID), .INSTRUCTION_ID(INSTRUCTION_ID), .valid_ID(valid_ID),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ SALT;

  function automatic logic [VW-1:0] obs_vec();
    return {valid_ID, PC_ID, INSTRUCTION_ID, count, full, empty, imem_addr};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    int sz = mq.size();
    logic [31:0] hp = (sz != 0) ? mq[0] : 32'h0;
    logic [31:0] hi = (sz != 0) ? (mq[0] ^ SALT) : NOP;
    return {sz != 0, hp, hi, CW'(sz), sz == DEPTH, sz == 0, mpc};
  endfunction

  task automatic model_reset();
    mq.delete();
    mpc = 32'h0;
  endtask

  task automatic model_step(input logic rdy, input logic br, input logic [31:0] tgt);
    bit do_pop, do_push;
    if (br) begin
      mq.delete();
      mpc = {tgt[31:2], 2'b00};
    end else begin
      do_pop  = (mq.size() > 0) && rdy;
      do_push = (mq.size() < DEPTH) || do_pop;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic cycle(input logic rdy, input logic br, input logic [31:0] tgt);
    ID_ready  = rdy;
    PCSrc     = br;
    PC_Branch = tgt;
    @(posedge clk);
    model_step(rdy, br, tgt);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; PCSrc = 1'b0; ID_ready = 1'b0; PC_Branch = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    compared++;
    if (obs_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), exp_vec());
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL stream_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      compared++;
      if ({valid_ID, PC_ID, count} !== {1'b1, 32'(4*i), CW'(1)}) begin
        mismatched++;
        $display("FAIL stream_seq i=%0d got=%b/%h/%0d exp=1/%h/1", i, valid_ID, PC_ID, count, 32'(4*i));
      end
    end
  endtask

  task automatic test_fill_drain();
    cycle(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL fill_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    compared++;
    if ({count, full, imem_addr, PC_ID} !== {CW'(4), 1'b1, 32'd16, 32'd0}) begin
      mismatched++;
      $display("FAIL fill_full got=%0d/%b/%h/%h exp=4/1/10/0", count, full, imem_addr, PC_ID);
    end
    for (int k = 0; k < 5; k++) begin
      compared++;
      if ({valid_ID, PC_ID} !== {1'b1, 32'(4*k)}) begin
        mismatched++;
        $display("FAIL drain_order k=%0d got=%b/%h exp=1/%h", k, valid_ID, PC_ID, 32'(4*k));
      end
      cycle(1'b1, 1'b0, 32'h0);
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL drain_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_full_stream();
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = imem_addr;
      cycle(1'b1, 1'b0, 32'h0);
      compared++;
      if ({count, full, imem_addr} !== {CW'(4), 1'b1, a + 32'd4}) begin
        mismatched++;
        $display("FAIL full_stream i=%0d got=%0d/%b/%h exp=4/1/%h", i, count, full, imem_addr, a + 32'd4);
      end
    end
  endtask

  task automatic test_redirect();
    cycle(1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    compared++;
    if (count !== CW'(3)) begin
      mismatched++;
      $display("FAIL redirect_prefill got=%0d exp=3", count);
    end
    cycle(1'b1, 1'b1, 32'h0000_0103);
    compared++;
    if ({count, valid_ID, INSTRUCTION_ID, PC_ID} !== {CW'(0), 1'b0, NOP, 32'h0}) begin
      mismatched++;
      $display("FAIL redirect_bubble got=%0d/%b/%h/%h exp=0/0/00000013/0", count, valid_ID, INSTRUCTION_ID, PC_ID);
    end
    cycle(1'b1, 1'b0, 32'h0);
    compared++;
    if ({valid_ID, PC_ID, INSTRUCTION_ID} !== {1'b1, 32'h100, 32'h100 ^ SALT}) begin
      mismatched++;
      $display("FAIL redirect_target got=%b/%h/%h exp=1/00000100/%h", valid_ID, PC_ID, INSTRUCTION_ID, 32'h100 ^ SALT);
    end
    compared++;
    if (obs_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL redirect_model got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0;
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      compared++;
      if ({valid_ID, PC_ID} !== {1'b1, want[i]}) begin
        mismatched++;
        $display("FAIL wrap_seq i=%0d got=%b/%h exp=1/%h", i, valid_ID, PC_ID, want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic rdy, br;
    logic [31:0] tgt;
    for (int i = 0; i < 300; i++) begin
      rdy = 1'($urandom_range(0, 3) != 0 ? (i % 40 < 20 ? 1 : $urandom_range(0, 1)) : 0);
      br  = 1'($urandom_range(0, 15) == 0);
      tgt = $urandom;
      cycle(rdy, br, tgt);
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b1, 32'h200);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    compared++;
    if ({count, PC_ID} !== {CW'(2), 32'h200}) begin
      mismatched++;
      $display("FAIL async_prefill got=%0d/%h exp=2/00000200", count, PC_ID);
    end
    PCSrc = 1'b1; PC_Branch = 32'h300;
    #1 reset = 1'b1;
    #1;
    model_reset();
    compared++;
    if ({valid_ID, count, empty, full, INSTRUCTION_ID, PC_ID, imem_addr} !== {1'b1 ^ 1'b1, CW'(0), 1'b1, 1'b0, NOP, 32'h0, 32'h0}) begin
      mismatched++;
      $display("FAIL async_reset got=%b/%0d/%b/%b/%h/%h/%h exp=0/0/1/0/00000013/0/0", valid_ID, count, empty, full, INSTRUCTION_ID, PC_ID, imem_addr);
    end
    #1 reset = 1'b0;
    cycle(1'b1, 1'b0, 32'h0);
    compared++;
    if ({valid_ID, PC_ID} !== {1'b1, 32'h0} || obs_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL async_restart got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_drain();
    test_full_stream();
    test_redirect();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
